// File: rtl/acq_pkg.sv
// Shared types and sizing helpers for the acquisition sample packer.
// The fill counter must hold values up to W+N_CH inclusive.
package acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RUN     = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_STALLED = 3'd4
    } acq_state_t;

    function automatic int fill_width(input int w, input int n_ch);
        return $clog2(w + n_ch + 1);
    endfunction

endpackage

// File: rtl/channel_compactor.sv
// Packs the enabled probe bits densely from bit 0 upward.
// It also reports how many bits are valid.
module channel_compactor #(
    parameter int N_CH = 16,
    parameter int KW   = $clog2(N_CH + 1)
) (
    input  logic [N_CH-1:0] probe,
    input  logic [N_CH-1:0] enable,
    output logic [N_CH-1:0] compacted,
    output logic [KW-1:0]   k
);

    // lowest enabled channel lands at bit 0; k doubles as the write position
    always_comb begin
        compacted = {N_CH{1'b0}};
        k         = {KW{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (enable[i]) begin
                compacted = compacted | (N_CH'(probe[i]) << k);
                k         = k + KW'(1);
            end else begin
                compacted = compacted;
            end
        end
    end

endmodule

// File: rtl/acq_sample_packer.sv
// Fast-domain acquisition core: rate divider, optional pattern trigger,
// dense packing of enabled channels into W-bit FIFO words, sticky overflow stall.
module acq_sample_packer
    import acq_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int W     = 16,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  probe,
    input  logic             acq_enable,
    input  logic [DIV_W-1:0] clock_divisor,
    input  logic [N_CH-1:0]  channel_enable,
    input  logic             trig_en,
    input  logic [N_CH-1:0]  trig_mask,
    input  logic [N_CH-1:0]  trig_value,
    input  logic             overflow,
    output logic [W-1:0]     sample_data,
    output logic             sample_data_avail,
    output logic             stalled,
    output logic             armed
);

    localparam int ACC_W = W + N_CH;
    localparam int FW    = fill_width(W, N_CH);
    localparam int KW    = $clog2(N_CH + 1);

    acq_state_t       state_r, state_s;
    logic [DIV_W-1:0] div_cnt_r, div_cnt_s, div_adv_s, div_sh_r;
    logic [N_CH-1:0]  en_sh_r, tmask_sh_r, tval_sh_r;
    logic [ACC_W-1:0] acc_r, acc_s, acc_sum_s, acc_pack_s;
    logic [FW-1:0]    fill_r, fill_s, fill_sum_s, fill_pack_s;
    logic [N_CH-1:0]  comp_s;
    logic [KW-1:0]    k_s;
    logic             tick_s, trig_hit_s, pack_emit_s, emit_s, latch_s;
    logic [W-1:0]     emit_data_s, data_r;
    logic             avail_r, stalled_r, armed_r;

    channel_compactor #(
        .N_CH (N_CH),
        .KW   (KW)
    ) u_compactor (
        .probe     (probe),
        .enable    (en_sh_r),
        .compacted (comp_s),
        .k         (k_s)
    );

    assign tick_s     = (div_cnt_r == div_sh_r);
    assign div_adv_s  = tick_s ? {DIV_W{1'b0}} : (div_cnt_r + DIV_W'(1));
    assign trig_hit_s = (((probe ^ tval_sh_r) & tmask_sh_r) == {N_CH{1'b0}});

    // append this tick's compacted bits above the current fill and split off a full word
    always_comb begin
        acc_sum_s   = acc_r | (ACC_W'(comp_s) << fill_r);
        fill_sum_s  = fill_r + FW'(k_s);
        pack_emit_s = (fill_sum_s >= FW'(W));
        if (pack_emit_s) begin
            acc_pack_s  = acc_sum_s >> W;
            fill_pack_s = fill_sum_s - FW'(W);
        end else begin
            acc_pack_s  = acc_sum_s;
            fill_pack_s = fill_sum_s;
        end
    end

    // next-state logic; overflow outranks the enable drop, and a tick on the drop cycle still packs
    always_comb begin
        state_s     = state_r;
        div_cnt_s   = div_cnt_r;
        acc_s       = acc_r;
        fill_s      = fill_r;
        emit_s      = 1'b0;
        emit_data_s = {W{1'b0}};
        latch_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (acq_enable) begin
                    latch_s   = 1'b1;
                    div_cnt_s = {DIV_W{1'b0}};
                    acc_s     = {ACC_W{1'b0}};
                    fill_s    = {FW{1'b0}};
                    state_s   = trig_en ? ST_ARMED : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                div_cnt_s = div_adv_s;
                if (!acq_enable) begin
                    state_s = ST_IDLE;
                end else if (tick_s && trig_hit_s) begin
                    state_s     = ST_RUN;
                    acc_s       = acc_pack_s;
                    fill_s      = fill_pack_s;
                    emit_s      = pack_emit_s;
                    emit_data_s = acc_sum_s[W-1:0];
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_RUN: begin
                div_cnt_s = div_adv_s;
                if (overflow) begin
                    state_s = ST_STALLED;
                end else begin
                    if (tick_s) begin
                        acc_s       = acc_pack_s;
                        fill_s      = fill_pack_s;
                        emit_s      = pack_emit_s;
                        emit_data_s = acc_sum_s[W-1:0];
                    end else begin
                        emit_s = 1'b0;
                    end
                    if (!acq_enable) begin
                        state_s = (fill_s != {FW{1'b0}}) ? ST_FLUSH : ST_IDLE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
            end
            ST_FLUSH: begin
                if (overflow) begin
                    state_s = ST_STALLED;
                end else begin
                    // bits above fill are always zero, so the low word is already padded
                    emit_s      = 1'b1;
                    emit_data_s = acc_r[W-1:0];
                    acc_s       = {ACC_W{1'b0}};
                    fill_s      = {FW{1'b0}};
                    state_s     = ST_IDLE;
                end
            end
            ST_STALLED: begin
                if (!acq_enable) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STALLED;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // state, shadow configuration, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= {DIV_W{1'b0}};
            div_sh_r   <= {DIV_W{1'b0}};
            en_sh_r    <= {N_CH{1'b0}};
            tmask_sh_r <= {N_CH{1'b0}};
            tval_sh_r  <= {N_CH{1'b0}};
            acc_r      <= {ACC_W{1'b0}};
            fill_r     <= {FW{1'b0}};
            data_r     <= {W{1'b0}};
            avail_r    <= 1'b0;
            stalled_r  <= 1'b0;
            armed_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            div_cnt_r <= div_cnt_s;
            acc_r     <= acc_s;
            fill_r    <= fill_s;
            if (latch_s) begin
                div_sh_r   <= clock_divisor;
                en_sh_r    <= channel_enable;
                tmask_sh_r <= trig_mask;
                tval_sh_r  <= trig_value;
            end
            avail_r <= emit_s;
            if (emit_s) begin
                data_r <= emit_data_s;
            end
            stalled_r <= (state_s == ST_STALLED);
            armed_r   <= (state_s == ST_ARMED);
        end
    end

    assign sample_data       = data_r;
    assign sample_data_avail = avail_r;
    assign stalled           = stalled_r;
    assign armed             = armed_r;

endmodule
